// File: rtl/rf_pkg.sv
// Shared constants and types for the register file and its read ports.
package rf_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int RF_SIZE    = 32;
  localparam int ADDR_SIZE  = 5;

  typedef logic [WORD_WIDTH-1:0] rf_word_t;
  typedef logic [ADDR_SIZE-1:0]  rf_addr_t;

endpackage : rf_pkg

// File: rtl/rf_read_port.sv
// One combinational read port: an enable-gated RF_SIZE:1 word mux.
// It drives zero when the port is disabled or the address has no register behind it.
module rf_read_port #(
  parameter int WORD_WIDTH = rf_pkg::WORD_WIDTH,
  parameter int RF_SIZE    = rf_pkg::RF_SIZE,
  parameter int ADDR_SIZE  = rf_pkg::ADDR_SIZE
) (
  input  logic                  en,
  input  logic [ADDR_SIZE-1:0]  addr,
  input  logic [WORD_WIDTH-1:0] words [RF_SIZE],
  output logic [WORD_WIDTH-1:0] data
);

  // A decoded compare per entry keeps out-of-range addresses at zero without indexing past the array.
  always_comb begin
    data = '0;
    if (en) begin
      for (int i = 0; i < RF_SIZE; i++) begin
        if (addr == ADDR_SIZE'(i)) data = words[i];
      end
    end
  end

endmodule : rf_read_port

// File: rtl/register_file.sv
// Operand store: RF_SIZE x WORD_WIDTH registers, two synchronous write ports
// (port 2 wins on collision) and three independent combinational read ports.
module register_file #(
  parameter int WORD_WIDTH = rf_pkg::WORD_WIDTH,
  parameter int RF_SIZE    = rf_pkg::RF_SIZE,
  parameter int ADDR_SIZE  = rf_pkg::ADDR_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  re1,
  input  logic                  re2,
  input  logic                  re3,
  input  logic [ADDR_SIZE-1:0]  ra1,
  input  logic [ADDR_SIZE-1:0]  ra2,
  input  logic [ADDR_SIZE-1:0]  ra3,
  input  logic                  we1,
  input  logic                  we2,
  input  logic [ADDR_SIZE-1:0]  wa1,
  input  logic [ADDR_SIZE-1:0]  wa2,
  input  logic [WORD_WIDTH-1:0] wd1,
  input  logic [WORD_WIDTH-1:0] wd2,
  output logic [WORD_WIDTH-1:0] rd1,
  output logic [WORD_WIDTH-1:0] rd2,
  output logic [WORD_WIDTH-1:0] rd3
);

  logic [WORD_WIDTH-1:0] mem [RF_SIZE];

  logic wr1_ok;
  logic wr2_ok;

  // An unknown enable never compares true, so it cannot trigger a write.
  assign wr1_ok = (we1 == 1'b1) && (32'(wa1) < RF_SIZE);
  assign wr2_ok = (we2 == 1'b1) && (32'(wa2) < RF_SIZE);

  // Port 2 is assigned last so it takes precedence when both target one register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_SIZE; i++) mem[i] <= '0;
    end else begin
      if (wr1_ok) mem[wa1] <= wd1;
      if (wr2_ok) mem[wa2] <= wd2;
    end
  end

  rf_read_port #(
    .WORD_WIDTH (WORD_WIDTH),
    .RF_SIZE    (RF_SIZE),
    .ADDR_SIZE  (ADDR_SIZE)
  ) u_read_port1 (
    .en    (re1),
    .addr  (ra1),
    .words (mem),
    .data  (rd1)
  );

  rf_read_port #(
    .WORD_WIDTH (WORD_WIDTH),
    .RF_SIZE    (RF_SIZE),
    .ADDR_SIZE  (ADDR_SIZE)
  ) u_read_port2 (
    .en    (re2),
    .addr  (ra2),
    .words (mem),
    .data  (rd2)
  );

  rf_read_port #(
    .WORD_WIDTH (WORD_WIDTH),
    .RF_SIZE    (RF_SIZE),
    .ADDR_SIZE  (ADDR_SIZE)
  ) u_read_port3 (
    .en    (re3),
    .addr  (ra3),
    .words (mem),
    .data  (rd3)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed and randomised checks of register_file against a plain array model.
`timescale 1ns/1ps
module tb_register_file;
  import rf_pkg::*;

  logic     clk;
  logic     rst_n;
  logic     re1, re2, re3;
  rf_addr_t ra1, ra2, ra3;
  logic     we1, we2;
  rf_addr_t wa1, wa2;
  rf_word_t wd1, wd2;
  rf_word_t rd1, rd2, rd3;

  rf_word_t model [RF_SIZE];
  int       checks;
  int       errors;

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .re1   (re1),
    .re2   (re2),
    .re3   (re3),
    .ra1   (ra1),
    .ra2   (ra2),
    .ra3   (ra3),
    .we1   (we1),
    .we2   (we2),
    .wa1   (wa1),
    .wa2   (wa2),
    .wd1   (wd1),
    .wd2   (wd2),
    .rd1   (rd1),
    .rd2   (rd2),
    .rd3   (rd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input rf_word_t obs, input rf_word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic rf_word_t expect_read(input logic en, input rf_addr_t a);
    if (!en || int'(a) >= RF_SIZE) return '0;
    return model[a];
  endfunction

  // Let the combinational reads settle, then compare all three ports.
  task automatic check_reads(input string tag);
    #1;
    chk({tag, "/rd1"}, rd1, expect_read(re1, ra1));
    chk({tag, "/rd2"}, rd2, expect_read(re2, ra2));
    chk({tag, "/rd3"}, rd3, expect_read(re3, ra3));
  endtask

  // One rising edge; the model commits the writes the DUT saw at that edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (we1 && int'(wa1) < RF_SIZE) model[wa1] = wd1;
      if (we2 && int'(wa2) < RF_SIZE) model[wa2] = wd2;
    end
    #2;
  endtask

  task automatic set_reads(input rf_addr_t a1, input rf_addr_t a2, input rf_addr_t a3);
    ra1 = a1; ra2 = a2; ra3 = a3;
    re1 = 1'b1; re2 = 1'b1; re3 = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < RF_SIZE; i++) model[i] = '0;
    rst_n = 1'b0;
    we1 = 1'b0; we2 = 1'b0; wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0;
    set_reads(5'd0, 5'd15, 5'd31);
    check_reads("reset_state");
    #12 rst_n = 1'b1;
    step();

    // Fill every register with all ones.
    for (int a = 0; a < RF_SIZE; a++) begin
      we1 = 1'b1; wa1 = rf_addr_t'(a); wd1 = 32'hFFFF_FFFF;
      step();
    end
    we1 = 1'b0;
    set_reads(5'd0, 5'd17, 5'd31);
    check_reads("fill_ones");

    // Asynchronous clear in the middle of a cycle; reads must drop with no edge.
    #1 rst_n = 1'b0;
    for (int i = 0; i < RF_SIZE; i++) model[i] = '0;
    for (int a = 0; a < RF_SIZE; a++) begin
      set_reads(rf_addr_t'(a), rf_addr_t'(a), rf_addr_t'(a));
      #0.2;
      chk("async_clear", rd1 | rd2 | rd3, '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Sweep: old value before the edge, new value right after it.
    for (int a = 0; a < RF_SIZE; a++) begin
      we1 = 1'b1; wa1 = rf_addr_t'(a); wd1 = 32'd5;
      set_reads(rf_addr_t'(a), rf_addr_t'(a), rf_addr_t'(a));
      check_reads("sweep_pre");
      chk("sweep_pre_zero", rd1, '0);
      step();
      check_reads("sweep_post");
      chk("sweep_post_five", rd2, 32'd5);
    end
    we1 = 1'b0;

    // Two writes to different registers in one edge.
    we1 = 1'b1; wa1 = 5'd3;  wd1 = 32'd512;
    we2 = 1'b1; wa2 = ~5'd3; wd2 = 32'd1372;
    step();
    we1 = 1'b0; we2 = 1'b0;
    set_reads(5'd3, 5'd28, 5'd4);
    check_reads("dual_write");
    chk("dual_write_p1", rd1, 32'd512);
    chk("dual_write_p2", rd2, 32'd1372);
    chk("dual_write_untouched", rd3, 32'd5);

    // Both ports hit register 7: port 2 wins.
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hAAAA;
    we2 = 1'b1; wa2 = 5'd7; wd2 = 32'h5555;
    step();
    we1 = 1'b0; we2 = 1'b0;
    set_reads(5'd7, 5'd7, 5'd7);
    check_reads("collision");
    chk("collision_value", rd1, 32'h5555);

    // Per-port read enables, no clock involvement.
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h1234;
    step();
    we1 = 1'b0;
    set_reads(5'd9, 5'd9, 5'd9);
    for (int p = 0; p < 3; p++) begin
      re1 = (p != 0); re2 = (p != 1); re3 = (p != 2);
      check_reads("read_enable");
      chk("read_enable_off", (p == 0) ? rd1 : (p == 1) ? rd2 : rd3, '0);
    end

    // Data and address present but enables low: register 10 must keep its value.
    we1 = 1'b0; we2 = 1'b0; wa1 = 5'd10; wa2 = 5'd10; wd1 = 32'hDEAD; wd2 = 32'hDEAD;
    repeat (4) step();
    set_reads(5'd10, 5'd10, 5'd10);
    check_reads("we_gating");
    chk("we_gating_value", rd1, 32'd5);

    // Randomised run against the array model.
    for (int c = 0; c < 1000; c++) begin
      we1 = 1'($urandom_range(0, 1)); we2 = 1'($urandom_range(0, 1));
      wa1 = rf_addr_t'($urandom); wa2 = ($urandom_range(0, 7) == 0) ? wa1 : rf_addr_t'($urandom);
      wd1 = rf_word_t'($urandom); wd2 = rf_word_t'($urandom);
      re1 = ($urandom_range(0, 3) != 0); re2 = ($urandom_range(0, 3) != 0); re3 = ($urandom_range(0, 3) != 0);
      ra1 = rf_addr_t'($urandom); ra2 = rf_addr_t'($urandom); ra3 = rf_addr_t'($urandom);
      check_reads("random");
      step();
    end
    we1 = 1'b0; we2 = 1'b0;
    for (int a = 0; a < RF_SIZE; a++) begin
      set_reads(rf_addr_t'(a), rf_addr_t'((a + 11) % RF_SIZE), rf_addr_t'((a + 23) % RF_SIZE));
      check_reads("final_scan");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_register_file

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose 32 x 32-bit register file with three independent read ports and two write ports.
- Writes are synchronous on the rising clock edge; reads are combinational.
- Serves as the operand store of the datapath: up to three source operands are read and up to two results are written per cycle.

Parameters:
- WORD_WIDTH, 32, bits per register and data-port width
- RF_SIZE, 32, number of registers
- ADDR_SIZE, 5, address width; must satisfy 2**ADDR_SIZE >= RF_SIZE

Ports:
- clk  in  1  sole clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- re1  in  1  read enable, port 1
- re2  in  1  read enable, port 2
- re3  in  1  read enable, port 3
- ra1  in  ADDR_SIZE  read address, port 1
- ra2  in  ADDR_SIZE  read address, port 2
- ra3  in  ADDR_SIZE  read address, port 3
- we1  in  1  write enable, port 1
- we2  in  1  write enable, port 2
- wa1  in  ADDR_SIZE  write address, port 1
- wa2  in  ADDR_SIZE  write address, port 2
- wd1  in  WORD_WIDTH  write data, port 1
- wd2  in  WORD_WIDTH  write data, port 2
- rd1  out  WORD_WIDTH  read data, port 1
- rd2  out  WORD_WIDTH  read data, port 2
- rd3  out  WORD_WIDTH  read data, port 3

Behaviour:
- Reset
  - rst_n low asynchronously clears all RF_SIZE registers to 0, independent of clk.
  - While rst_n is low, writes are ignored and rd1/rd2/rd3 read 0.
  - Deassertion takes effect on the next rising edge; no other state exists.
- Write
  - On the rising edge of clk with rst_n high: if weN=1, reg[waN] <= wdN.
  - weN=0: no change for that port.
- Dual write
  - we1 and we2 both 1 with different addresses: both registers update in the same edge.
  - Same address: port 2 wins, so reg gets wd2.
- Register 0
  - Ordinary, fully writable storage; it is not hardwired to zero.
- Read
  - rdN = reNr ? reg[raN] : 0, purely combinational with zero-cycle latency.
  - All three ports are independent and may use the same address.
- Read-during-write
  - Before the edge, rdN shows the old contents; after the edge, it shows the new value in the same cycle.
  - There is no internal bypass of wd to rd.
- Out-of-range addresses (raN/waN >= RF_SIZE, only possible with a non-default RF_SIZE)
  - Reads return 0; writes are dropped.
- X/Z on a weN input must not corrupt storage; treat a non-1 value as disabled.

Decomposition:
- Shared package rf_pkg holds:
  - the constants WORD_WIDTH, RF_SIZE, ADDR_SIZE;
  - typedefs rf_word_t (logic [WORD_WIDTH-1:0]) and rf_addr_t (logic [ADDR_SIZE-1:0]).
- One natural sub-module, rf_read_port: a gated, combinational RF_SIZE:1 word multiplexer with enable, out-of-range guard and zero output.
  - Instantiate it three times.
- The storage array and write logic stay in the top module.

Test Plan:
- Reset clear: write 0xFFFFFFFF to all 32 registers, pulse rst_n low mid-cycle -> with re1..3=1, every address reads 0 immediately, without a clock edge.
- Sweep write/read: for a=0..31, we1=1, wa1=a, wd1=5, ra1=ra2=ra3=a, re1..3=1.
  - Before the edge, rd1..3 = 0 (prior value).
  - 2 ns after the rising edge, rd1..3 = 5.
  - Includes address 0, which reads 5.
- Dual write: we1=we2=1, wa1=3, wd1=512, wa2=~3=28, wd2=1372, one edge -> ra1=3 reads 512, ra2=28 reads 1372, ra3=4 reads unchanged.
- Write collision: we1=we2=1, wa1=wa2=7, wd1=0xAAAA, wd2=0x5555 -> reg 7 reads 0x5555.
- Read enables: reg 9=0x1234, ra1..3=9, toggle re1..3 individually -> disabled port reads 0 and enabled ports read 0x1234, with no clock needed.
- Write-enable gating: we1=we2=0, wd1=wd2=0xDEAD to address 10 over 4 edges -> reg 10 keeps its prior value. Randomised scoreboard run of 1000 cycles matches the reference model on all three read ports every cycle.
